// File: rtl/spell_mem_loader.sv
// rtl/spell_mem_loader.sv - byte-stream host loader driving single-byte memory accesses
// Frames are CMD, ADDR, LEN, payload; each byte becomes one select/ready handshake on the memory port.
module spell_mem_loader (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       mem_select,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic [1:0] mem_type,
   output logic       mem_write,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready,
   output logic       busy,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_WDATA,
      S_WMEM,
      S_RMEM,
      S_ROUT
   } state_t;

   state_t     state_q;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       mem_select_q;
   logic       mem_write_q;
   logic       busy_q;
   logic       error_q;
   logic       is_read_q;
   logic [7:0] out_data_q;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] rem_q;
   logic [1:0] type_q;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // in_ready_q sits at 1 through reset so the host sees ready on the first cycle after release
   assign in_ready   = in_ready_q & reset_n;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign mem_select = mem_select_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_type   = type_q;
   assign mem_write  = mem_write_q;
   assign busy       = busy_q;
   assign error      = error_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         mem_select_q <= 1'b0;
         mem_write_q  <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
         is_read_q    <= 1'b0;
         out_data_q   <= 8'h00;
         addr_q       <= 8'h00;
         wdata_q      <= 8'h00;
         rem_q        <= 8'h00;
         type_q       <= 2'b00;
      end else begin
         case (state_q)
            S_IDLE: if (in_fire) begin
               type_q    <= in_data[1:0];
               is_read_q <= in_data[6];
               case (in_data[7:6])
                  2'b00, 2'b01: begin
                     state_q <= S_ADDR;
                     busy_q  <= 1'b1;
                  end
                  2'b10:   error_q <= 1'b0;
                  default: error_q <= 1'b1;
               endcase
            end
            S_ADDR: if (in_fire) begin
               addr_q  <= in_data;
               state_q <= S_LEN;
            end
            S_LEN: if (in_fire) begin
               rem_q <= in_data;
               if (is_read_q) begin
                  state_q      <= S_RMEM;
                  in_ready_q   <= 1'b0;
                  mem_select_q <= 1'b1;
                  mem_write_q  <= 1'b0;
               end else begin
                  state_q <= S_WDATA;
               end
            end
            S_WDATA: if (in_fire) begin
               wdata_q      <= in_data;
               mem_write_q  <= 1'b1;
               mem_select_q <= 1'b1;
               in_ready_q   <= 1'b0;
               state_q      <= S_WMEM;
            end
            // Dropping select here guarantees the deselect cycle the memory needs to rearm
            S_WMEM: if (mem_ready) begin
               mem_select_q <= 1'b0;
               in_ready_q   <= 1'b1;
               addr_q       <= addr_q + 8'd1;
               if (rem_q == 8'd0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rem_q   <= rem_q - 8'd1;
                  state_q <= S_WDATA;
               end
            end
            S_RMEM: if (mem_ready) begin
               out_data_q   <= mem_rdata;
               out_valid_q  <= 1'b1;
               mem_select_q <= 1'b0;
               state_q      <= S_ROUT;
            end
            S_ROUT: if (out_fire) begin
               out_valid_q <= 1'b0;
               addr_q      <= addr_q + 8'd1;
               if (rem_q == 8'd0) begin
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
               end else begin
                  rem_q        <= rem_q - 8'd1;
                  mem_select_q <= 1'b1;
                  state_q      <= S_RMEM;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
